ps2_host_tx: RTL

- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the host to the keyboard using the PS/2 host-request protocol.
- Drives the shared open-drain ps2_clk/ps2_data lines through active-high pull-low enables. Samples them through its own synchronizers.
- Sits beside the existing keyboard receiver. While `busy`=1, the receiver's input is gated off by the top level.

---
 rtl/ps2_host_tx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Sends one command byte from the host to a PS/2 device (keyboard) using the
// host-request protocol: inhibit the clock, present the start bit, release the
// clock, then shift data/parity/stop on each device falling edge and read the
// device's ack bit.
//
// Handshake: a byte is accepted on a rising clk edge where tx_valid && tx_ready.
// tx_data is captured only at that edge. tx_valid is ignored at all other times.
// done pulses once at the end of every accepted transfer. err_nack and
// err_timeout are valid with done and are held until the next accept.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   tx_data[7:0]    command byte to send
//   tx_valid        request to send tx_data
//   tx_ready        block idle, a request is accepted this cycle
//   ps2_clk_i       raw PS/2 clock line level (asynchronous)
//   ps2_data_i      raw PS/2 data line level (asynchronous)
//   ps2_clk_low     1 = pull PS/2 clock line low (open-drain enable)
//   ps2_data_low    1 = pull PS/2 data line low (open-drain enable)
//   busy            transfer in progress (state other than IDLE)
//   done            one-cycle end-of-transfer pulse
//   err_nack        device did not drive the ack bit low
//   err_timeout     transfer aborted because the device stopped clocking
//   state_dbg[2:0]  current FSM state, for debug and checkers
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       busy,
  output logic       done,
  output logic       err_nack,
  output logic       err_timeout,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic             clk_s1, clk_s2, clk_prev;
  logic             data_s1, data_s2;
  logic [9:0]       sr;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             clk_low_q, data_low_q;
  logic             done_q, err_nack_q, err_to_q;

  logic fall;
  logic lines_idle;
  logic to_active;
  logic timed_out;

  assign fall       = clk_prev & ~clk_s2;
  assign lines_idle = clk_s2 & data_s2;
  assign to_active  = (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE);

  // A device edge or the bus going idle in the same cycle as the limit counts
  // as progress, so the timeout only fires when nothing else is happening.
  always_comb begin
    timed_out = 1'b0;
    if (to_active && (to_cnt == TO_LAST) && !fall &&
        !((state == S_WAIT_IDLE) && lines_idle)) begin
      timed_out = 1'b1;
    end
  end

  // The cycle carrying done still sees state IDLE, so readiness waits one
  // more cycle before a new request can be taken.
  assign tx_ready     = (state == S_IDLE) && !done_q;
  assign busy         = (state != S_IDLE);
  assign done         = done_q;
  assign err_nack     = err_nack_q;
  assign err_timeout  = err_to_q;
  assign ps2_clk_low  = clk_low_q;
  assign ps2_data_low = data_low_q;
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_prev   <= 1'b1;
      data_s1    <= 1'b1;
      data_s2    <= 1'b1;
      state      <= S_IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      done_q     <= 1'b0;
      err_nack_q <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk_i;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_i;
      data_s2  <= data_s1;
      done_q   <= 1'b0;

      if (timed_out) begin
        clk_low_q  <= 1'b0;
        data_low_q <= 1'b0;
        done_q     <= 1'b1;
        err_to_q   <= 1'b1;
        err_nack_q <= 1'b0;
        state      <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (tx_valid && tx_ready) begin
              // Frame goes out LSB first: d0..d7, odd parity, stop.
              sr         <= {1'b1, ~^tx_data, tx_data};
              bit_cnt    <= '0;
              inh_cnt    <= '0;
              to_cnt     <= '0;
              err_nack_q <= 1'b0;
              err_to_q   <= 1'b0;
              clk_low_q  <= 1'b1;
              data_low_q <= 1'b0;
              state      <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              // Start bit goes on the data line while the clock is still held.
              data_low_q <= 1'b1;
              state      <= S_START;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          S_START: begin
            clk_low_q <= 1'b0;
            to_cnt    <= '0;
            state     <= S_SHIFT;
          end
          S_SHIFT: begin
            if (fall) begin
              data_low_q <= ~sr[0];
              sr         <= {1'b0, sr[9:1]};
              bit_cnt    <= bit_cnt + 1'b1;
              to_cnt     <= '0;
              if (bit_cnt == 4'd9) begin
                state <= S_ACK;
              end
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          S_ACK: begin
            if (fall) begin
              err_nack_q <= data_s2;
              to_cnt     <= '0;
              state      <= S_WAIT_IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          S_WAIT_IDLE: begin
            if (lines_idle) begin
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: begin
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            state      <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
